// File: rtl/regfile_dump_reader_pkg.sv
// Shared encodings and default sizes for the register-file dump reader.
package regfile_dump_reader_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned NREGS_DEF = 4;
  localparam int unsigned SELW_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SEND    = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready beat stream carrying {addr, data, last} from the dump reader to its consumer.
interface regfile_dump_reader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SELW  = 2
);
  logic             out_valid;
  logic             out_ready;
  logic [SELW-1:0]  out_addr;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (output out_valid, output out_addr, output out_data, output out_last,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_addr, input  out_data, input  out_last,
                  output out_ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks every register through one register_file read port and streams {addr,data}
// beats; blocks register_file writes while a dump is in flight so the dump is a snapshot.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned SELW  = SELW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [SELW-1:0]  rd_sel,
  input  logic [WIDTH-1:0] rd_data,
  output logic             wr_block,
  output logic             busy,
  output logic             done,
  regfile_dump_reader_if.master out_if
);

  localparam logic [SELW-1:0] LAST_IDX = SELW'(NREGS - 1);

  state_e           state_q, state_d;
  logic [SELW-1:0]  idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hs;

  assign hs = (state_q == ST_SEND) && valid_q && out_if.out_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_SEND;
      ST_SEND:    if (hs) state_d = last_q ? ST_IDLE : ST_CAPTURE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; beat fields hold by default so SEND is stable under backpressure
  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: idx_d = '0;
      ST_CAPTURE: begin
        data_d  = rd_data;
        addr_d  = idx_q;
        last_d  = (idx_q == LAST_IDX);
        valid_d = 1'b1;
      end
      ST_SEND: begin
        if (hs) begin
          valid_d = 1'b0;
          if (last_q) begin
            done_d = 1'b1;
            idx_d  = '0;
          end else begin
            idx_d  = idx_q + SELW'(1);
          end
        end
      end
      default: idx_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rd_sel           = idx_q;
  assign busy             = busy_q;
  assign wr_block         = busy_q;
  assign done             = done_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_addr  = addr_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_last  = last_q;

endmodule
